pipe_ctrl: RTL and testbench

- Pipeline control unit; the producer side of the flush/stall protocol consumed by the IF/ID and ID/EX pipeline registers (drives id_ex_dff_pipeline_flush_flag and peers).
- Arbitrates EX-stage jump/branch redirects, ID-stage load-use hazards and EX multi-cycle busy.
- Emits per-stage flush, per-stage stall and the PC redirect.
- Sits beside the five-stage core datapath in hdl/core.

---
 rtl/pipe_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: arbitrates EX redirects, EX busy and ID load-use hazards
// into per-stage flush/stall controls and the PC redirect. Perf counters under CTRL_PERF_CNT_EN.
module pipe_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_jump_flag_i,
    input  logic [ADDR_WIDTH-1:0] ctrl_jump_addr_i,
    input  logic                  ctrl_load_use_i,
    input  logic                  ctrl_ex_busy_i,
    output logic                  ctrl_pc_jump_flag_o,
    output logic [ADDR_WIDTH-1:0] ctrl_pc_jump_addr_o,
    output logic                  ctrl_if_id_flush_o,
    output logic                  ctrl_id_ex_flush_o,
    output logic                  ctrl_pc_stall_o,
    output logic                  ctrl_if_id_stall_o,
    output logic                  ctrl_id_ex_stall_o,
    output logic                  ctrl_busy_err_o,
    output logic [31:0]           ctrl_flush_cnt_o,
    output logic [31:0]           ctrl_stall_cnt_o
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    localparam bit         HAS_FLUSH = (FLUSH_CYCLES > 0);
    localparam logic [1:0] FCNT_LOAD = HAS_FLUSH ? 2'(FLUSH_CYCLES - 1) : 2'd0;
    localparam logic [7:0] BCNT_MAX  = 8'(BUSY_TIMEOUT);

    state_t     state_reg, state_next;
    logic [1:0] fcnt_reg, fcnt_next;
    logic [7:0] bcnt_reg, bcnt_next;
    logic       err_reg, err_next;

    logic       jump_comb;
    logic       if_id_flush_comb;
    logic       id_ex_flush_comb;
    logic       pc_stall_comb;
    logic       if_id_stall_comb;
    logic       id_ex_stall_comb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_RUN;
            fcnt_reg  <= 2'd0;
            bcnt_reg  <= 8'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= fcnt_next;
            bcnt_reg  <= bcnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        fcnt_next        = fcnt_reg;
        bcnt_next        = bcnt_reg;
        jump_comb        = 1'b0;
        if_id_flush_comb = 1'b0;
        id_ex_flush_comb = 1'b0;
        pc_stall_comb    = 1'b0;
        if_id_stall_comb = 1'b0;
        id_ex_stall_comb = 1'b0;

        if (ctrl_jump_flag_i) begin
            // A jump wins in every state; a jump inside the flush window restarts it.
            jump_comb        = 1'b1;
            if_id_flush_comb = 1'b1;
            id_ex_flush_comb = 1'b1;
            bcnt_next        = 8'd0;
            if (HAS_FLUSH) begin
                state_next = S_FLUSH;
                fcnt_next  = FCNT_LOAD;
            end else begin
                state_next = S_RUN;
                fcnt_next  = 2'd0;
            end
        end else begin
            case (state_reg)
                S_FLUSH: begin
                    if_id_flush_comb = 1'b1;
                    id_ex_flush_comb = 1'b1;
                    if (fcnt_reg == 2'd0) begin
                        state_next = S_RUN;
                    end else begin
                        fcnt_next = fcnt_reg - 2'd1;
                    end
                end
                default: begin
                    // S_RUN and S_BUSY share the same arbitration; only bcnt handling differs.
                    if (ctrl_ex_busy_i) begin
                        pc_stall_comb    = 1'b1;
                        if_id_stall_comb = 1'b1;
                        id_ex_stall_comb = 1'b1;
                        state_next       = S_BUSY;
                        if (state_reg == S_BUSY) begin
                            bcnt_next = (bcnt_reg == BCNT_MAX) ? bcnt_reg : bcnt_reg + 8'd1;
                        end else begin
                            bcnt_next = 8'd1;
                        end
                    end else begin
                        state_next = S_RUN;
                        bcnt_next  = 8'd0;
                        if (ctrl_load_use_i) begin
                            pc_stall_comb    = 1'b1;
                            if_id_stall_comb = 1'b1;
                            id_ex_flush_comb = 1'b1;
                        end
                    end
                end
            endcase
        end

        err_next = err_reg | (bcnt_next == BCNT_MAX);
    end

    // Outputs are forced low while reset is held, independent of the inputs.
    assign ctrl_pc_jump_flag_o = rst_n & jump_comb;
    assign ctrl_pc_jump_addr_o = ctrl_pc_jump_flag_o ? ctrl_jump_addr_i : '0;
    assign ctrl_if_id_flush_o  = rst_n & if_id_flush_comb;
    assign ctrl_id_ex_flush_o  = rst_n & id_ex_flush_comb;
    assign ctrl_pc_stall_o     = rst_n & pc_stall_comb;
    assign ctrl_if_id_stall_o  = rst_n & if_id_stall_comb & ~if_id_flush_comb;
    assign ctrl_id_ex_stall_o  = rst_n & id_ex_stall_comb & ~id_ex_flush_comb;
    assign ctrl_busy_err_o     = err_reg;

`ifdef CTRL_PERF_CNT_EN
    logic [1:0]       perf_inc;
    logic [1:0][31:0] perf_cnt;

    assign perf_inc[0] = ctrl_pc_jump_flag_o;
    assign perf_inc[1] = ctrl_pc_stall_o;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= 32'd0;
                end else if (perf_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
            assign perf_cnt[gi] = cnt_reg;
        end
    endgenerate

    assign ctrl_flush_cnt_o = perf_cnt[0];
    assign ctrl_stall_cnt_o = perf_cnt[1];
`else
    assign ctrl_flush_cnt_o = 32'd0;
    assign ctrl_stall_cnt_o = 32'd0;
`endif

`ifndef SYNTHESIS
    a_if_id_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(ctrl_if_id_flush_o && ctrl_if_id_stall_o));
    a_id_ex_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(ctrl_id_ex_flush_o && ctrl_id_ex_stall_o));
    a_addr_zero: assert property (@(posedge clk) disable iff (!rst_n)
        ctrl_pc_jump_flag_o || (ctrl_pc_jump_addr_o == '0));
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic against
// a cycle-level behavioural model of the flush/stall rules.
module tb_pipe_ctrl;

    localparam int AW = 32;
    localparam int FC = 1;
    localparam int BT = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          jump;
    logic [AW-1:0] jaddr;
    logic          load_use;
    logic          busy;
    logic          pc_jump_flag;
    logic [AW-1:0] pc_jump_addr;
    logic          if_id_flush, id_ex_flush;
    logic          pc_stall, if_id_stall, id_ex_stall;
    logic          busy_err;
    logic [31:0]   flush_cnt, stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .BUSY_TIMEOUT(BT)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ctrl_jump_flag_i    (jump),
        .ctrl_jump_addr_i    (jaddr),
        .ctrl_load_use_i     (load_use),
        .ctrl_ex_busy_i      (busy),
        .ctrl_pc_jump_flag_o (pc_jump_flag),
        .ctrl_pc_jump_addr_o (pc_jump_addr),
        .ctrl_if_id_flush_o  (if_id_flush),
        .ctrl_id_ex_flush_o  (id_ex_flush),
        .ctrl_pc_stall_o     (pc_stall),
        .ctrl_if_id_stall_o  (if_id_stall),
        .ctrl_id_ex_stall_o  (id_ex_stall),
        .ctrl_busy_err_o     (busy_err),
        .ctrl_flush_cnt_o    (flush_cnt),
        .ctrl_stall_cnt_o    (stall_cnt)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: remaining extra flush cycles, consecutive busy cycles, sticky error, perf totals.
    int          m_flush_left, n_flush_left;
    int          m_busy_run,   n_busy_run;
    bit          m_err,        n_err;
    logic [31:0] m_fc, n_fc, m_sc, n_sc;
    logic [102:0] exp_v;

    function automatic logic [102:0] obs();
        return {pc_jump_flag, pc_jump_addr, if_id_flush, id_ex_flush,
                pc_stall, if_id_stall, id_ex_stall, busy_err, flush_cnt, stall_cnt};
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_busy_run   = 0;
        m_err        = 1'b0;
        m_fc         = 32'd0;
        m_sc         = 32'd0;
    endtask

    task automatic model_eval();
        logic pcj, f1, f2, s0, s1, s2;
        logic [AW-1:0] ad;
        logic [31:0] fcv, scv;
        pcj = 0; f1 = 0; f2 = 0; s0 = 0; s1 = 0; s2 = 0; ad = '0;
        n_flush_left = m_flush_left;
        n_busy_run   = m_busy_run;
        n_err        = m_err;
        if (jump) begin
            pcj = 1; ad = jaddr; f1 = 1; f2 = 1;
            n_flush_left = FC;
            n_busy_run   = 0;
        end else if (m_flush_left > 0) begin
            f1 = 1; f2 = 1;
            n_flush_left = m_flush_left - 1;
            n_busy_run   = 0;
        end else if (busy) begin
            s0 = 1; s1 = 1; s2 = 1;
            n_busy_run = (m_busy_run + 1 > BT) ? BT : m_busy_run + 1;
            if (n_busy_run >= BT) n_err = 1'b1;
        end else begin
            n_busy_run = 0;
            if (load_use) begin
                s0 = 1; s1 = 1; f2 = 1;
            end
        end
        n_fc = (pcj && m_fc != 32'hFFFF_FFFF) ? m_fc + 1 : m_fc;
        n_sc = (s0 && m_sc != 32'hFFFF_FFFF) ? m_sc + 1 : m_sc;
`ifdef CTRL_PERF_CNT_EN
        fcv = m_fc; scv = m_sc;
`else
        fcv = 32'd0; scv = 32'd0;
`endif
        exp_v = {pcj, ad, f1, f2, s0, s1, s2, m_err, fcv, scv};
    endtask

    task automatic apply(input logic j, input logic [AW-1:0] a, input logic lu, input logic b);
        @(negedge clk);
        jump = j; jaddr = a; load_use = lu; busy = b;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        m_flush_left = n_flush_left;
        m_busy_run   = n_busy_run;
        m_err        = n_err;
        m_fc         = n_fc;
        m_sc         = n_sc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        jump = 1'b1; jaddr = $urandom; load_use = 1'b1; busy = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (obs() !== 103'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h expected 0", obs());
        end
        @(negedge clk);
        jump = 0; jaddr = '0; load_use = 0; busy = 0;
        rst_n = 1'b1;
        apply(0, '0, 0, 0);
        compared++;
        if (obs() !== exp_v) begin
            mismatched++;
            $display("FAIL reset_release: got %h expected %h", obs(), exp_v);
        end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_jump();
        for (int i = 0; i < 4; i++) begin
            apply(i == 0, (i == 0) ? 32'h0000_0100 : 32'h0000_0000, 0, 0);
            compared++;
            if (obs() !== exp_v) begin
                mismatched++;
                $display("FAIL jump cycle %0d: got %h expected %h", i, obs(), exp_v);
            end
            tick();
        end
        $display("test_jump done");
    endtask

    task automatic test_jump_restart();
        logic [AW-1:0] addrs [5] = '{32'h100, 32'h200, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            // busy/load_use during the flush window must be ignored
            apply(i < 2, addrs[i], i == 2, i == 2);
            compared++;
            if (obs() !== exp_v) begin
                mismatched++;
                $display("FAIL jump_restart cycle %0d: got %h expected %h", i, obs(), exp_v);
            end
            tick();
        end
        apply(0, '0, 0, 0);
        tick();
        $display("test_jump_restart done");
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 3; i++) begin
            apply(0, $urandom, i == 0, 0);
            compared++;
            if (obs() !== exp_v) begin
                mismatched++;
                $display("FAIL load_use cycle %0d: got %h expected %h", i, obs(), exp_v);
            end
            tick();
        end
        $display("test_load_use done");
    endtask

    task automatic test_busy();
        int lens [2] = '{BT - 1, BT};
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < lens[r] + 3; i++) begin
                apply(0, '0, i == lens[r] + 1, i < lens[r]);
                compared++;
                if (obs() !== exp_v) begin
                    mismatched++;
                    $display("FAIL busy run %0d cycle %0d: got %h expected %h", r, i, obs(), exp_v);
                end
                tick();
            end
            #1;
            compared++;
            if (busy_err !== (r == 1)) begin
                mismatched++;
                $display("FAIL busy_err after %0d cycles: got %b expected %b", lens[r], busy_err, r == 1);
            end
        end
        $display("test_busy done");
    endtask

    task automatic test_reset_mid_busy();
        for (int i = 0; i < 5; i++) begin
            apply(0, '0, 0, 1);
            tick();
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compared++;
        if (obs() !== 103'd0) begin
            mismatched++;
            $display("FAIL reset_mid_busy: got %h expected 0", obs());
        end
        model_reset();
        @(negedge clk);
        busy = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(i == 1, 32'hCAFE_0000, 0, 0);
            compared++;
            if (obs() !== exp_v) begin
                mismatched++;
                $display("FAIL after_reset cycle %0d: got %h expected %h", i, obs(), exp_v);
            end
            tick();
        end
        apply(0, '0, 0, 0);
        tick();
        $display("test_reset_mid_busy done");
    endtask

    task automatic test_all_together();
        logic [31:0] fc0, sc0;
        fc0 = flush_cnt;
        sc0 = stall_cnt;
        for (int i = 0; i < 3; i++) begin
            apply(i == 0, 32'h0000_0ABC, i == 0, i == 0);
            compared++;
            if (obs() !== exp_v) begin
                mismatched++;
                $display("FAIL all_together cycle %0d: got %h expected %h", i, obs(), exp_v);
            end
            tick();
        end
`ifdef CTRL_PERF_CNT_EN
        #1;
        compared++;
        if (flush_cnt !== fc0 + 32'd1 || stall_cnt !== sc0) begin
            mismatched++;
            $display("FAIL perf_counts: got flush %0d stall %0d expected flush %0d stall %0d",
                     flush_cnt, stall_cnt, fc0 + 32'd1, sc0);
        end
`endif
        $display("test_all_together done (flush_cnt %0d stall_cnt %0d at start)", fc0, sc0);
    endtask

    task automatic test_random();
        logic b;
        b = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) b = ~b;
            apply($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) == 0, b);
            compared++;
            if (obs() !== exp_v) begin
                mismatched++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs(), exp_v);
            end
            tick();
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_jump();
        test_jump_restart();
        test_load_use();
        test_busy();
        test_reset_mid_busy();
        test_all_together();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
